// File: rtl/controle_contador.sv
`default_nettype none
// ============================================================================
// Module      : controle_contador
// Description : Programmable modulo-N counter with a run-control FSM
//               (IDLE / RUN / HOLD / DONE). Supports up/down counting,
//               preset loading, one-shot or continuous wrap-around, and
//               exposes terminal-count and status flags for cascading.
//               All state updates happen on the falling edge of clk.
// Ports       : clk     - clock (falling-edge active)
//               clr     - asynchronous active-low reset
//               start   - begin / resume / restart counting (level)
//               stop    - pause, or abort to idle (level)
//               load    - load preset value into the count (level)
//               up      - direction, 1 = up, 0 = down
//               cont    - 1 = continuous wrap-around, 0 = one-shot
//               modulo  - count range 0..modulo-1 (0 means 2^WIDTH)
//               preset  - value for load and restart (clamped to last)
//               q       - current count (registered)
//               tc      - terminal count flag (RUN and q at terminal)
//               busy    - high in RUN or HOLD
//               done    - high in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module controle_contador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic             up,
    input  logic             cont,
    input  logic [WIDTH-1:0] modulo,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_pv;
    logic [WIDTH-1:0] w_term;
    logic             w_at_term;
    logic             w_out_of_range;

    // Modulo of zero wraps naturally to all ones, giving the full 2^WIDTH range.
    assign w_last         = modulo - C_ONE;
    assign w_pv           = (preset <= w_last) ? preset : w_last;
    assign w_term         = up ? w_last : '0;
    assign w_at_term      = (r_q == w_term);
    // Only reachable when modulo shrinks while a count is in progress.
    assign w_out_of_range = (r_q > w_last);

    // State and count register, falling-edge clocked.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        unique case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_q_nxt = w_pv;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_HOLD;
                end else if (load) begin
                    w_q_nxt = w_pv;
                end else if (w_out_of_range) begin
                    // Pull back into range; counts as an ordinary step.
                    w_q_nxt = up ? w_last : '0;
                end else if (w_at_term) begin
                    if (cont) begin
                        w_q_nxt = up ? '0 : w_last;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_q_nxt = up ? (r_q + C_ONE) : (r_q - C_ONE);
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (load) begin
                    w_q_nxt = w_pv;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (load) begin
                    w_q_nxt     = w_pv;
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_q_nxt     = w_pv;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign q    = r_q;
    assign tc   = (r_state == S_RUN) && w_at_term;
    assign busy = (r_state == S_RUN) || (r_state == S_HOLD);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_controle_contador.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_contador
// Description : Self-checking bench for controle_contador. The stimulus
//               process pushes the expected {q, tc, busy, done} for each
//               falling edge (or asynchronous reset) into a queue; a
//               separate monitor pops and compares after each update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_contador;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clr;
    logic             start;
    logic             stop;
    logic             load;
    logic             up;
    logic             cont;
    logic [WIDTH-1:0] modulo;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    // Expected {q, tc, busy, done}
    logic [WIDTH+2:0] exp_q[$];
    int               n_checks;
    int               n_pass;
    int               step_id;
    event             ev_chk;

    controle_contador #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .stop   (stop),
        .load   (load),
        .up     (up),
        .cont   (cont),
        .modulo (modulo),
        .preset (preset),
        .q      (q),
        .tc     (tc),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Monitor: after every falling edge or asynchronous event, pop and compare.
    initial begin
        logic [WIDTH+2:0] e;
        logic [WIDTH+2:0] a;
        forever begin
            @(negedge clk or ev_chk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {q, tc, busy, done};
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL chk%0d q/tc/busy/done: got q=%0d tc=%b busy=%b done=%b, need q=%0d tc=%b busy=%b done=%b",
                             n_checks, a[WIDTH+2:3], a[2], a[1], a[0],
                             e[WIDTH+2:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Drive control levels for one edge and queue the expected post-edge result.
    task automatic t(input logic s, input logic sp, input logic ld,
                     input logic [WIDTH-1:0] eq, input logic etc,
                     input logic eb, input logic ed);
        start = s;
        stop  = sp;
        load  = ld;
        exp_q.push_back({eq, etc, eb, ed});
        step_id++;
        @(negedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        step_id  = 0;
        clr      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        load     = 1'b0;
        up       = 1'b1;
        cont     = 1'b1;
        modulo   = 4'd10;
        preset   = 4'd0;

        // Reset state
        #2;
        exp_q.push_back({4'd0, 1'b0, 1'b0, 1'b0});
        -> ev_chk;
        #1 clr = 1'b1;

        // Continuous up, modulo 10
        t(0, 0, 1, 4'd0, 0, 0, 0);
        t(1, 0, 0, 4'd0, 0, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            t(0, 0, 0, 4'(k), (k == 9), 1, 0);
        end
        t(0, 0, 0, 4'd0, 0, 1, 0);
        t(0, 0, 0, 4'd1, 0, 1, 0);

        // Pause / resume at q = 4
        t(0, 0, 0, 4'd2, 0, 1, 0);
        t(0, 0, 0, 4'd3, 0, 1, 0);
        t(0, 0, 0, 4'd4, 0, 1, 0);
        t(0, 1, 0, 4'd4, 0, 1, 0);
        t(0, 0, 0, 4'd4, 0, 1, 0);
        t(0, 0, 0, 4'd4, 0, 1, 0);
        t(1, 0, 0, 4'd4, 0, 1, 0);
        t(0, 0, 0, 4'd5, 0, 1, 0);
        t(0, 1, 0, 4'd5, 0, 1, 0);
        t(0, 1, 0, 4'd5, 0, 0, 0);

        // Reset mid-run at q = 7
        t(1, 0, 0, 4'd5, 0, 1, 0);
        t(0, 0, 0, 4'd6, 0, 1, 0);
        t(0, 0, 0, 4'd7, 0, 1, 0);
        clr = 1'b0;
        exp_q.push_back({4'd0, 1'b0, 1'b0, 1'b0});
        -> ev_chk;
        #2;
        t(1, 0, 0, 4'd0, 0, 0, 0);   // start ignored while clr low
        clr = 1'b1;
        t(0, 0, 0, 4'd0, 0, 0, 0);   // idle: no counting without start
        t(1, 0, 0, 4'd0, 0, 1, 0);
        t(0, 0, 0, 4'd1, 0, 1, 0);
        t(0, 1, 0, 4'd1, 0, 1, 0);
        t(0, 1, 0, 4'd1, 0, 0, 0);

        // One-shot down, modulo 6, preset 3
        modulo = 4'd6;
        preset = 4'd3;
        cont   = 1'b0;
        up     = 1'b0;
        t(0, 0, 1, 4'd3, 0, 0, 0);
        t(1, 0, 0, 4'd3, 0, 1, 0);
        t(0, 0, 0, 4'd2, 0, 1, 0);
        t(0, 0, 0, 4'd1, 0, 1, 0);
        t(0, 0, 0, 4'd0, 1, 1, 0);
        t(0, 0, 0, 4'd0, 0, 0, 1);
        t(0, 0, 0, 4'd0, 0, 0, 1);
        t(0, 0, 0, 4'd0, 0, 0, 1);
        t(0, 0, 0, 4'd0, 0, 0, 1);
        t(1, 0, 0, 4'd3, 0, 1, 0);
        t(0, 1, 0, 4'd3, 0, 1, 0);
        t(0, 1, 0, 4'd3, 0, 0, 0);

        // Full range, modulo 0
        modulo = 4'd0;
        preset = 4'd14;
        cont   = 1'b1;
        up     = 1'b1;
        t(0, 0, 1, 4'd14, 0, 0, 0);
        t(1, 0, 0, 4'd14, 0, 1, 0);
        t(0, 0, 0, 4'd15, 1, 1, 0);
        t(0, 0, 0, 4'd0,  0, 1, 0);
        t(0, 0, 0, 4'd1,  0, 1, 0);
        t(0, 1, 0, 4'd1,  0, 1, 0);
        t(0, 1, 0, 4'd1,  0, 0, 0);

        // Boundaries, modulo 5
        modulo = 4'd5;
        preset = 4'd9;
        t(0, 0, 1, 4'd4, 0, 0, 0);   // preset clamped to last
        preset = 4'd2;
        t(1, 0, 1, 4'd2, 0, 0, 0);   // load beats start in IDLE
        t(1, 0, 0, 4'd2, 0, 1, 0);
        t(1, 1, 0, 4'd2, 0, 1, 0);   // stop beats start in RUN -> HOLD
        t(0, 1, 0, 4'd2, 0, 0, 0);

        // Modulo shrink mid-run: q = 8 with new last = 4
        modulo = 4'd10;
        preset = 4'd8;
        t(0, 0, 1, 4'd8, 0, 0, 0);
        t(1, 0, 0, 4'd8, 0, 1, 0);
        modulo = 4'd5;
        t(0, 0, 0, 4'd4, 1, 1, 0);
        t(0, 0, 0, 4'd0, 0, 1, 0);

        // Direction change mid-run (down from 0 wraps to last = 4)
        up = 1'b0;
        t(0, 0, 0, 4'd4, 0, 1, 0);
        t(0, 0, 0, 4'd3, 0, 1, 0);
        t(0, 1, 0, 4'd3, 0, 1, 0);
        t(0, 1, 0, 4'd3, 0, 0, 0);

        // One-shot up ending in DONE, then load from DONE -> IDLE
        up     = 1'b1;
        cont   = 1'b0;
        modulo = 4'd3;
        preset = 4'd1;
        t(0, 0, 1, 4'd1, 0, 0, 0);
        t(1, 0, 0, 4'd1, 0, 1, 0);
        t(0, 0, 0, 4'd2, 1, 1, 0);
        t(0, 0, 0, 4'd2, 0, 0, 1);
        preset = 4'd0;
        t(0, 0, 1, 4'd0, 0, 0, 0);

        #20;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got step %0d, need completion", step_id);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/controle_contador.md
# controle_contador

Programmable modulo-N counter with a run-control state machine. It owns the count register, direction, modulus, preset loading and one-shot/continuous sequencing that the lab's counter chains otherwise get from hand-wired JK stages. A top-level exercise instantiates it between the panel switches and buttons and the display decoder. It exposes terminal-count and status flags for cascading.

## Interface
- WIDTH, 4, count register width in bits.

- clk  input  1  clock; all state updates on the falling edge.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  begin, resume or restart counting (level, sampled each falling edge).
- stop  input  1  pause, or abort to idle (level, sampled).
- load  input  1  load preset into count (level, sampled).
- up  input  1  direction: 1 counts up, 0 counts down.
- cont  input  1  1 selects continuous wrap-around; 0 selects one-shot.
- modulo  input  WIDTH  count range 0..modulo-1; 0 means 2^WIDTH.
- preset  input  WIDTH  value for load and restart.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count flag.
- busy  output  1  high in RUN or HOLD.
- done  output  1  high in DONE.

## Operation
- last = (modulo - 1) truncated to WIDTH bits, so modulo = 0 gives all ones.
- Terminal value is last when up = 1, and 0 when up = 0.
- pv is the load value: preset when preset <= last, otherwise last.
- States are IDLE, RUN, HOLD and DONE. The encoding is internal.
- IDLE:
  - load → q <= pv, stay IDLE.
  - else start → RUN, q unchanged.
  - Priority: load over start. stop is ignored.
- RUN:
  - stop → HOLD, q unchanged. stop has priority over everything.
  - else load → q <= pv, stay RUN.
  - else if q is the terminal value:
    - cont = 1 → wrap: up gives q <= 0, down gives q <= last.
    - cont = 0 → DONE, q held.
  - else step q by +1 when up = 1, or -1 when up = 0.
- HOLD:
  - stop → IDLE, q held.
  - else load → q <= pv, stay HOLD.
  - else start → RUN.
- DONE:
  - stop → IDLE.
  - else load → q <= pv, go IDLE.
  - else start → q <= pv, go RUN.
  - q is held otherwise.
- Direction may change mid-run. The new direction applies from the next falling edge.
- If modulo changes mid-run and q > new last, the next RUN step sets q <= last for up and q <= 0 for down; this counts as a step, not a terminal event. Steps then continue normally.
- tc = (state == RUN) and (q == terminal value). It is combinational from registered state and q.
- busy and done are decoded from the state register only.

## Timing
- Reset (clr = 0), applied at any time and independent of clk:
  - q = 0, state = IDLE, busy = 0, done = 0, tc = 0.
  - Held while clr = 0.
  - Normal operation resumes at the first falling edge after clr rises.
- Inputs must be stable around each falling edge. There is no internal synchronisation.
- Start latency: start sampled at falling edge n → RUN after n with q unchanged. The first step happens at edge n+1.
- Stop latency: stop at edge n → HOLD after n, and q keeps its pre-edge value.
- tc rises in the same cycle q reaches the terminal value while in RUN. It falls after the next edge.
- One-shot end: at the falling edge where tc = 1 → DONE, done = 1, tc = 0, q held.
- busy, done and q change only on falling edges or on clr.

## Test plan
- Reset mid-run (WIDTH = 4, modulo = 10, q = 7, RUN): drive clr = 0 between edges → immediately q = 0, busy = 0, done = 0, tc = 0. After release, start is needed before counting.
- Continuous up (modulo = 10, preset = 0, cont = 1): load, then start → q steps 0…9. tc = 1 only while q = 9. The next edge gives q = 0, busy stays 1, and no DONE.
- One-shot down (modulo = 6, preset = 3, cont = 0, up = 0): load, start → q = 3, 2, 1, 0. tc = 1 at q = 0. The next edge gives done = 1, busy = 0, and q holds 0 for 4 edges. Then start → q = 3, RUN.
- Full range (modulo = 0, up = 1, cont = 1, preset = 14): q = 14, 15 (tc = 1), 0, 1.
- Pause/resume (modulo = 10, up): stop sampled when q = 4 → q = 4 for 3 edges with busy = 1, tc = 0. Then start → RUN; the next edge gives q = 5. Then stop twice → IDLE, busy = 0.
- Boundaries (modulo = 5): preset = 9 with load → q = 4. stop and start on the same edge in RUN → HOLD. load and start on the same edge in IDLE → q = pv, stays IDLE.
